// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between the fetch and data ports.
// One transaction at a time; alternating priority under contention, ack pulse on completion.
module mem_arbiter #(
  parameter int WIDTH     = 32,
  parameter int ADDRWIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 if_req_i,
  input  logic [ADDRWIDTH-1:0] if_addr_i,
  output logic [WIDTH-1:0]     if_rdata_o,
  output logic                 if_ack_o,
  input  logic [1:0]           dm_ctrl_i,
  input  logic [ADDRWIDTH-1:0] dm_addr_i,
  input  logic [WIDTH-1:0]     dm_wdata_i,
  output logic [WIDTH-1:0]     dm_rdata_o,
  output logic                 dm_ack_o,
  output logic                 stall_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [ADDRWIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]     mem_wdata_o,
  input  logic [WIDTH-1:0]     mem_rdata_i,
  input  logic                 mem_ready_i
);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, RESP} state_t;

  state_t                 state_q;
  logic                   last_d_q;
  logic                   mem_req_q;
  logic                   mem_we_q;
  logic [ADDRWIDTH-1:0]   mem_addr_q;
  logic [WIDTH-1:0]       mem_wdata_q;
  logic [WIDTH-1:0]       if_rdata_q;
  logic [WIDTH-1:0]       dm_rdata_q;
  logic                   if_ack_q;
  logic                   dm_ack_q;
  logic                   dm_req;

  assign dm_req = |dm_ctrl_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
    end else begin
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Data wins unless the fetch port is also waiting and data had the last grant.
          if (dm_req && (!if_req_i || !last_d_q)) begin
            state_q     <= DBUSY;
            mem_req_q   <= 1'b1;
            mem_we_q    <= dm_ctrl_i[1];
            mem_addr_q  <= dm_addr_i;
            mem_wdata_q <= dm_wdata_i;
          end else if (if_req_i) begin
            state_q     <= IBUSY;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr_i;
            mem_wdata_q <= '0;
          end
        end
        IBUSY: begin
          if (mem_ready_i) begin
            mem_req_q  <= 1'b0;
            if_rdata_q <= mem_rdata_i;
            last_d_q   <= 1'b0;
            if_ack_q   <= 1'b1;
            state_q    <= RESP;
          end
        end
        DBUSY: begin
          if (mem_ready_i) begin
            mem_req_q <= 1'b0;
            // A 2'b11 control was issued as a write, so nothing is captured for it either.
            if (!mem_we_q) dm_rdata_q <= mem_rdata_i;
            last_d_q  <= 1'b1;
            dm_ack_q  <= 1'b1;
            state_q   <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign dm_ack_o    = dm_ack_q;

  // The acked port sees its stall drop in the ack cycle so the pipeline steps once.
  assign stall_o = (if_req_i & ~if_ack_q) | (dm_req & ~dm_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, fetch, contention, wait-state write,
// 2'b11 control and asynchronous reset in the middle of an access.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic [1:0]  dm_ctrl;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.WIDTH(32), .ADDRWIDTH(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ack_o(if_ack),
    .dm_ctrl_i(dm_ctrl), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_rdata_o(dm_rdata), .dm_ack_o(dm_ack), .stall_o(stall),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = 0; dm_ctrl = 0; dm_addr = 0; dm_wdata = 0;
    mem_rdata = 0; mem_ready = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, if_ack, dm_ack, stall} !== '0) begin
      errors++; $display("FAIL reset_outputs got req=%b we=%b addr=%h ack=%b%b stall=%b exp all 0",
                         mem_req, mem_we, mem_addr, if_ack, dm_ack, stall);
    end
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (mem_req !== 1'b0 || stall !== 1'b0 || if_ack !== 1'b0 || dm_ack !== 1'b0) begin
        errors++; $display("FAIL reset_idle cyc %0d got req=%b stall=%b acks=%b%b exp 0", i, mem_req, stall, if_ack, dm_ack);
      end
    end
  endtask

  task automatic test_fetch();
    if_req = 1; if_addr = 32'h10;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL fetch_stall0 got %b exp 1", stall); end
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0 || if_ack !== 1'b0 || stall !== 1'b1) begin
      errors++; $display("FAIL fetch_issue got req=%b addr=%h we=%b ack=%b stall=%b exp 1 10 0 0 1",
                         mem_req, mem_addr, mem_we, if_ack, stall);
    end
    mem_ready = 1; mem_rdata = 32'h8C220004;
    tick();
    checks++;
    if (mem_req !== 1'b0 || if_ack !== 1'b1 || if_rdata !== 32'h8C220004 || stall !== 1'b0) begin
      errors++; $display("FAIL fetch_ack got req=%b ack=%b rdata=%h stall=%b exp 0 1 8c220004 0",
                         mem_req, if_ack, if_rdata, stall);
    end
    if_req = 0; mem_ready = 0; mem_rdata = 0;
    tick();
    checks++;
    if (if_ack !== 1'b0 || mem_req !== 1'b0 || if_rdata !== 32'h8C220004) begin
      errors++; $display("FAIL fetch_after got ack=%b req=%b rdata=%h exp 0 0 8c220004", if_ack, mem_req, if_rdata);
    end
  endtask

  task automatic test_simultaneous();
    idle_inputs();
    rst_n = 0; tick(); rst_n = 1; tick();
    if_req = 1; if_addr = 32'h40; dm_ctrl = 2'b01; dm_addr = 32'h44;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h44 || mem_we !== 1'b0) begin
      errors++; $display("FAIL sim_first_grant got req=%b addr=%h we=%b exp 1 44 0", mem_req, mem_addr, mem_we);
    end
    mem_ready = 1; mem_rdata = 32'h5;
    tick();
    checks++;
    if (dm_ack !== 1'b1 || if_ack !== 1'b0 || dm_rdata !== 32'h5 || stall !== 1'b1) begin
      errors++; $display("FAIL sim_data_ack got dack=%b iack=%b drdata=%h stall=%b exp 1 0 5 1",
                         dm_ack, if_ack, dm_rdata, stall);
    end
    mem_ready = 0; mem_rdata = 0;
    tick();
    checks++;
    if (mem_req !== 1'b0 || dm_ack !== 1'b0) begin
      errors++; $display("FAIL sim_resp_noarb got req=%b dack=%b exp 0 0", mem_req, dm_ack);
    end
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin
      errors++; $display("FAIL sim_second_grant got req=%b addr=%h exp 1 40", mem_req, mem_addr);
    end
    mem_ready = 1; mem_rdata = 32'h7;
    tick();
    checks++;
    if (if_ack !== 1'b1 || dm_ack !== 1'b0 || if_rdata !== 32'h7 || dm_rdata !== 32'h5 || stall !== 1'b1) begin
      errors++; $display("FAIL sim_fetch_ack got iack=%b dack=%b irdata=%h drdata=%h stall=%b exp 1 0 7 5 1",
                         if_ack, dm_ack, if_rdata, dm_rdata, stall);
    end
    if_req = 0; mem_ready = 0; mem_rdata = 0;
    tick(); tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h44) begin
      errors++; $display("FAIL sim_third_grant got req=%b addr=%h exp 1 44", mem_req, mem_addr);
    end
    mem_ready = 1; mem_rdata = 32'h9;
    tick();
    checks++;
    if (dm_ack !== 1'b1 || dm_rdata !== 32'h9 || if_rdata !== 32'h7) begin
      errors++; $display("FAIL sim_third_ack got dack=%b drdata=%h irdata=%h exp 1 9 7", dm_ack, dm_rdata, if_rdata);
    end
    dm_ctrl = 0; mem_ready = 0; mem_rdata = 0;
    tick();
  endtask

  task automatic test_write_wait();
    dm_ctrl = 2'b10; dm_addr = 32'h20; dm_wdata = 32'hDEADBEEF;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'hDEADBEEF ||
          dm_ack !== 1'b0 || stall !== 1'b1) begin
        errors++; $display("FAIL wr_hold cyc %0d got req=%b we=%b addr=%h wdata=%h ack=%b stall=%b exp 1 1 20 deadbeef 0 1",
                           i, mem_req, mem_we, mem_addr, mem_wdata, dm_ack, stall);
      end
      tick();
    end
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || dm_ack !== 1'b0) begin
      errors++; $display("FAIL wr_hold_last got req=%b we=%b ack=%b exp 1 1 0", mem_req, mem_we, dm_ack);
    end
    mem_ready = 1; mem_rdata = 32'hCAFEF00D;
    tick();
    checks++;
    if (dm_ack !== 1'b1 || mem_req !== 1'b0 || dm_rdata !== 32'h9 || if_ack !== 1'b0) begin
      errors++; $display("FAIL wr_ack got ack=%b req=%b drdata=%h iack=%b exp 1 0 9 0", dm_ack, mem_req, dm_rdata, if_ack);
    end
    dm_ctrl = 0; mem_ready = 0; mem_rdata = 0;
    tick();
    checks++;
    if (dm_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_pulse got %b exp 0", dm_ack); end
  endtask

  task automatic test_illegal_ctrl();
    int acks;
    dm_ctrl = 2'b11; dm_addr = 32'h30; dm_wdata = 32'h12345678;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h30 || mem_wdata !== 32'h12345678) begin
      errors++; $display("FAIL ill_issue got req=%b we=%b addr=%h wdata=%h exp 1 1 30 12345678",
                         mem_req, mem_we, mem_addr, mem_wdata);
    end
    mem_ready = 1; mem_rdata = 32'hFFFFFFFF;
    tick();
    acks = 0;
    if (dm_ack === 1'b1) acks++;
    checks++;
    if (dm_rdata !== 32'h9) begin errors++; $display("FAIL ill_rdata got %h exp 9", dm_rdata); end
    dm_ctrl = 0; mem_ready = 0; mem_rdata = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dm_ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 1) begin errors++; $display("FAIL ill_ack_count got %0d exp 1", acks); end
  endtask

  task automatic test_reset_midtx();
    dm_ctrl = 2'b01; dm_addr = 32'h50;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h50) begin
      errors++; $display("FAIL mid_issue got req=%b addr=%h exp 1 50", mem_req, mem_addr);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL mid_async_drop got req=%b addr=%h exp 0 0", mem_req, mem_addr);
    end
    dm_ctrl = 0; mem_ready = 1; mem_rdata = 32'hABCD;
    tick();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dm_ack !== 1'b0 || if_ack !== 1'b0 || mem_req !== 1'b0 || dm_rdata !== 32'h0) begin
        errors++; $display("FAIL mid_no_ack cyc %0d got dack=%b iack=%b req=%b drdata=%h exp 0 0 0 0",
                           i, dm_ack, if_ack, mem_req, dm_rdata);
      end
    end
    mem_ready = 0; mem_rdata = 0;
    if_req = 1; if_addr = 32'h60;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h60) begin
      errors++; $display("FAIL mid_idle_after got req=%b addr=%h exp 1 60", mem_req, mem_addr);
    end
    mem_ready = 1; mem_rdata = 32'h11;
    tick();
    checks++;
    if (if_ack !== 1'b1 || if_rdata !== 32'h11) begin
      errors++; $display("FAIL mid_fetch_ack got ack=%b rdata=%h exp 1 11", if_ack, if_rdata);
    end
    if_req = 0; mem_ready = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_simultaneous();
    test_write_wait();
    test_illegal_ctrl();
    test_reset_midtx();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
